clkdiv_cfg_sequencer: RTL and testbench
=======================================

Name: clkdiv_cfg_sequencer

Overview:
- Owns the enable and division-ratio inputs of one clock divider instance.
- Arbitrates ratio-change requests from two sources: A = register file, B = power manager.
- Applies each change glitch-safely: gate the divider, load the new ratio, re-enable, then wait one full output period before acknowledging.
- Sits in the reference-clock domain, directly in front of the divider.

Parameters:
- RATIO_WD, 8, width of every ratio bus.
- RESET_RATIO, 8'd2, ratio driven on o_div_ratio out of reset.
- GATE_CYC, 4, reference cycles o_clk_en is held low before a new ratio is loaded (range 1..15).

Ports:
- i_ref_clk  input  1  reference clock; the only clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_enable  input  1  global divider enable from configuration.
- i_req_a_valid  input  1  requester A ratio-change request.
- i_req_a_ratio  input  RATIO_WD  requested ratio from A.
- o_req_a_ready  output  1  A request accepted this cycle.
- i_req_b_valid  input  1  requester B ratio-change request.
- i_req_b_ratio  input  RATIO_WD  requested ratio from B.
- o_req_b_ready  output  1  B request accepted this cycle.
- o_div_ratio  output  RATIO_WD  ratio to the divider.
- o_clk_en  output  1  enable to the divider.
- o_busy  output  1  high in every state except IDLE.
- o_cfg_done  output  1  one-cycle pulse when a change completes.
- o_grant_id  output  1  requester of the most recent accept (0 = A, 1 = B).

Behaviour:
- Reset values: o_div_ratio = RESET_RATIO, o_clk_en = 0, o_busy = 0, o_cfg_done = 0, both readys = 0, o_grant_id = 1 (so A wins first), state = IDLE, counter = 0.
- All outputs are registered.
- States: IDLE, GATE, LOAD, UNGATE, SETTLE.
- Handshake: a transfer occurs when valid && ready. Ready is a one-cycle pulse, asserted only from IDLE.
- Once a requester has asserted valid, it holds valid and ratio stable until ready.
- Arbitration (round-robin):
  - If both requesters are valid, the one not equal to o_grant_id wins.
  - If only one is valid, it wins.
  - The accept cycle updates o_grant_id.
- IDLE:
  - o_clk_en <= i_enable every cycle.
  - On an accept with ratio == o_div_ratio: ready pulse, then o_cfg_done pulses the next cycle. No gating; stay in IDLE.
  - On an accept with a different ratio: capture it into new_ratio, counter <= 0, go to GATE.
- GATE:
  - o_clk_en <= 0.
  - counter increments each cycle.
  - When counter == GATE_CYC-1, go to LOAD.
- LOAD: o_div_ratio <= new_ratio; go to UNGATE. Lasts exactly 1 cycle.
- UNGATE:
  - o_clk_en <= i_enable; counter <= 0.
  - If i_enable = 0, skip SETTLE: pulse o_cfg_done and go to IDLE.
  - Otherwise go to SETTLE.
- SETTLE:
  - Counter runs to settle_len-1, where settle_len = new_ratio, or 1 if new_ratio < 2 (divider bypasses for ratios 0/1).
  - Counter is RATIO_WD bits wide; no wrap, because the terminal value is < 2^RATIO_WD.
  - At the terminal count: o_cfg_done pulses, go to IDLE.
- i_enable falling mid-sequence: o_clk_en goes low the next cycle in any state. The sequence still completes; the final o_clk_en follows i_enable.
- Requests arriving while busy are held off (ready = 0). They are not queued beyond the requester's own valid.
- Latency from accept to o_cfg_done, for a changed ratio R >= 2: GATE_CYC + 2 + R cycles.
- Reset mid-sequence: immediate return to reset values. The partially captured ratio is discarded.

Optional Feature:
- Macro: CLKDIV_SEQ_RATIO_CHECK_EN.
- With the macro defined:
  - Adds output o_cfg_err (1 bit, reset 0).
  - A request whose ratio is 0 or 1 is still accepted (ready pulses).
  - That request is not applied: o_cfg_err pulses one cycle in place of o_cfg_done, and o_div_ratio and o_clk_en are unchanged.
- Without the macro:
  - Port o_cfg_err is absent.
  - Ratios 0/1 are applied normally with settle_len = 1.

Test Plan:
- Reset, i_enable = 1, no requests -> o_div_ratio = 2; o_clk_en = 1 one cycle after reset release; o_busy = 0.
- A requests ratio 6, GATE_CYC = 4 -> o_req_a_ready pulses once; o_clk_en low for 4 cycles; o_div_ratio = 6 after LOAD; o_cfg_done 12 cycles after accept.
- A and B both valid in IDLE with o_grant_id = 1 -> A accepted first (ratio 4), then B (ratio 9) immediately after A's o_cfg_done; o_grant_id reads 0, then 1.
- B requests ratio equal to current (2) -> ready pulse, o_cfg_done next cycle, o_clk_en never drops, o_busy stays 0.
- i_enable dropped during SETTLE of ratio 8 -> o_clk_en = 0 the next cycle; o_cfg_done still pulses at the terminal count; o_clk_en stays 0.
- With CLKDIV_SEQ_RATIO_CHECK_EN, A requests ratio 1 -> ready pulse, o_cfg_err pulses, o_div_ratio unchanged, o_cfg_done never asserts.

Source files
------------

// File: rtl/clkdiv_cfg_sequencer.sv
// Clock-divider configuration sequencer.
// Arbitrates ratio-change requests from the register file (A) and the power
// manager (B), then applies each change glitch-safely: gate the divider,
// load the new ratio, re-enable, and wait one output period before
// reporting completion on o_cfg_done.
// Optional build macro CLKDIV_SEQ_RATIO_CHECK_EN: ratios 0/1 are accepted but
// rejected with an o_cfg_err pulse instead of being applied.
module clkdiv_cfg_sequencer #(
    parameter int                     RATIO_WD    = 8,
    parameter logic [RATIO_WD-1:0]    RESET_RATIO = RATIO_WD'(2),
    parameter int                     GATE_CYC    = 4
) (
    input  logic                i_ref_clk,
    input  logic                i_rst,
    input  logic                i_enable,
    input  logic                i_req_a_valid,
    input  logic [RATIO_WD-1:0] i_req_a_ratio,
    output logic                o_req_a_ready,
    input  logic                i_req_b_valid,
    input  logic [RATIO_WD-1:0] i_req_b_ratio,
    output logic                o_req_b_ready,
    output logic [RATIO_WD-1:0] o_div_ratio,
    output logic                o_clk_en,
    output logic                o_busy,
    output logic                o_cfg_done,
`ifdef CLKDIV_SEQ_RATIO_CHECK_EN
    output logic                o_cfg_err,
`endif
    output logic                o_grant_id
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATE,
        ST_LOAD,
        ST_UNGATE,
        ST_SETTLE
    } state_t;

    localparam logic [RATIO_WD-1:0] GATE_LAST = RATIO_WD'(GATE_CYC - 1);
    localparam logic [RATIO_WD-1:0] ONE       = RATIO_WD'(1);
    localparam logic [RATIO_WD-1:0] TWO       = RATIO_WD'(2);

    state_t              state_q, state_d;
    logic [RATIO_WD-1:0] cnt_q, cnt_d;
    logic [RATIO_WD-1:0] new_ratio_q, new_ratio_d;
    logic [RATIO_WD-1:0] ratio_q, ratio_d;
    logic                grant_q, grant_d;
    logic                en_q, en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ready_a_q, ready_a_d;
    logic                ready_b_q, ready_b_d;
`ifdef CLKDIV_SEQ_RATIO_CHECK_EN
    logic                err_q, err_d;
    logic                req_bad;
    logic                ack_bad;
`endif

    logic                can_accept;
    logic                pick_b;
    logic                take;
    logic                apply;
    logic [RATIO_WD-1:0] req_ratio;
    logic [RATIO_WD-1:0] settle_last;

    // Round-robin pick: with both valid the requester that did not win last
    // time goes; a new accept is blocked while the previous ready pulse is
    // still out, because the requester's valid is still high that cycle.
    assign can_accept = (state_q == ST_IDLE) && !ready_a_q && !ready_b_q;
    assign pick_b     = (i_req_a_valid && i_req_b_valid) ? ~grant_q : i_req_b_valid;
    assign take       = can_accept && (i_req_a_valid || i_req_b_valid);
    assign req_ratio  = pick_b ? i_req_b_ratio : i_req_a_ratio;

`ifdef CLKDIV_SEQ_RATIO_CHECK_EN
    assign req_bad = (req_ratio < TWO);
    assign ack_bad = (new_ratio_q < TWO);
    assign apply   = (req_ratio != ratio_q) && !req_bad;
`else
    assign apply   = (req_ratio != ratio_q);
`endif

    // The divider bypasses for ratios 0/1, so one cycle is a full period there.
    assign settle_last = (new_ratio_q < TWO) ? '0 : (new_ratio_q - ONE);

    // State and registered-output storage.
    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            new_ratio_q <= '0;
            ratio_q     <= RESET_RATIO;
            grant_q     <= 1'b1;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_a_q   <= 1'b0;
            ready_b_q   <= 1'b0;
`ifdef CLKDIV_SEQ_RATIO_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            new_ratio_q <= new_ratio_d;
            ratio_q     <= ratio_d;
            grant_q     <= grant_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ready_a_q   <= ready_a_d;
            ready_b_q   <= ready_b_d;
`ifdef CLKDIV_SEQ_RATIO_CHECK_EN
            err_q       <= err_d;
`endif
        end
    end

    // Next-state, sequencing counter and captured-request bookkeeping.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        new_ratio_d = new_ratio_q;
        grant_d     = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    new_ratio_d = req_ratio;
                    grant_d     = pick_b;
                    if (apply) begin
                        cnt_d   = '0;
                        state_d = ST_GATE;
                    end
                end
            end
            ST_GATE: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == GATE_LAST) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_UNGATE;
            end
            ST_UNGATE: begin
                cnt_d   = '0;
                state_d = i_enable ? ST_SETTLE : ST_IDLE;
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == settle_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        ratio_d   = ratio_q;
        en_d      = i_enable;
        busy_d    = (state_d != ST_IDLE);
        done_d    = 1'b0;
        ready_a_d = 1'b0;
        ready_b_d = 1'b0;
`ifdef CLKDIV_SEQ_RATIO_CHECK_EN
        err_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    ready_a_d = ~pick_b;
                    ready_b_d = pick_b;
                end
                // Still idle one cycle after an accept: nothing to apply,
                // so report completion (or rejection) right away.
                if (ready_a_q || ready_b_q) begin
`ifdef CLKDIV_SEQ_RATIO_CHECK_EN
                    if (ack_bad) begin
                        err_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
`else
                    done_d = 1'b1;
`endif
                end
            end
            ST_GATE: begin
                en_d = 1'b0;
            end
            ST_LOAD: begin
                en_d    = 1'b0;
                ratio_d = new_ratio_q;
            end
            ST_UNGATE: begin
                done_d = ~i_enable;
            end
            ST_SETTLE: begin
                done_d = (cnt_q == settle_last);
            end
            default: begin
                en_d = 1'b0;
            end
        endcase
    end

    assign o_div_ratio   = ratio_q;
    assign o_clk_en      = en_q;
    assign o_busy        = busy_q;
    assign o_cfg_done    = done_q;
    assign o_req_a_ready = ready_a_q;
    assign o_req_b_ready = ready_b_q;
    assign o_grant_id    = grant_q;
`ifdef CLKDIV_SEQ_RATIO_CHECK_EN
    assign o_cfg_err     = err_q;
`endif

endmodule

// File: tb/tb_clkdiv_cfg_sequencer.sv
// Bench for clkdiv_cfg_sequencer: directed scenarios with literal
// expectations plus a randomized run, all checked every cycle against a
// timeline model (outputs derived from the accept cycle and the latency
// rules of the sequencer).
module tb_clkdiv_cfg_sequencer;

    localparam int          RW    = 8;
    localparam int          G     = 4;
    localparam logic [7:0]  RST_R = 8'd2;
`ifdef CLKDIV_SEQ_RATIO_CHECK_EN
    localparam bit          CHK   = 1'b1;
`else
    localparam bit          CHK   = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          va, vb;
    logic [RW-1:0] ra, rb;
    logic          ready_a, ready_b;
    logic [RW-1:0] div_ratio;
    logic          clk_en, busy, cfg_done, grant_id;
`ifdef CLKDIV_SEQ_RATIO_CHECK_EN
    logic          cfg_err;
`endif

    always #5 clk = ~clk;

    clkdiv_cfg_sequencer #(
        .RATIO_WD   (RW),
        .RESET_RATIO(RST_R),
        .GATE_CYC   (G)
    ) dut (
        .i_ref_clk    (clk),
        .i_rst        (rst),
        .i_enable     (en),
        .i_req_a_valid(va),
        .i_req_a_ratio(ra),
        .o_req_a_ready(ready_a),
        .i_req_b_valid(vb),
        .i_req_b_ratio(rb),
        .o_req_b_ready(ready_b),
        .o_div_ratio  (div_ratio),
        .o_clk_en     (clk_en),
        .o_busy       (busy),
        .o_cfg_done   (cfg_done),
`ifdef CLKDIV_SEQ_RATIO_CHECK_EN
        .o_cfg_err    (cfg_err),
`endif
        .o_grant_id   (grant_id)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // Timeline model: a changed-ratio sequence is described only by its
    // accept cycle m_a, target m_R and completion cycle m_done.
    int m_active = 0, m_a = 0, m_R = 0, m_done = -1, m_ack = -1;
    bit m_ack_err = 1'b0;
    int m_ratio = int'(RST_R);
    bit m_grant = 1'b1;
    bit e_ready_a = 0, e_ready_b = 0, e_done = 0, e_err = 0, e_busy = 0, e_en = 0;
    bit e_grant = 1'b1;
    int e_ratio = int'(RST_R);

    function automatic int settle_len(input int r);
        return (r < 2) ? 1 : r;
    endfunction

    // Advance the model to the cycle that begins at this edge, from the
    // inputs that were stable across the edge.
    task automatic model_step();
        int  n;
        bit  was_idle, was_ready, win_b;
        int  r;
        cyc++;
        n = cyc;
        if (rst) begin
            m_active = 0; m_done = -1; m_ack = -1;
            m_ratio = int'(RST_R); m_grant = 1'b1;
            e_ready_a = 0; e_ready_b = 0; e_done = 0; e_err = 0;
            e_busy = 0; e_en = 0; e_grant = 1'b1; e_ratio = int'(RST_R);
        end else begin
            was_idle  = !e_busy;
            was_ready = e_ready_a | e_ready_b;
            e_ready_a = 0; e_ready_b = 0; e_done = 0; e_err = 0;
            e_en = en;
            if (m_active != 0) begin
                if (n >= m_a + 1 && n <= m_a + G + 1) e_en = 1'b0;
                if (n == m_a + G + 1) m_ratio = m_R;
                if (n - 1 == m_a + G + 1)
                    m_done = en ? (m_a + G + 2 + settle_len(m_R)) : (m_a + G + 2);
                if (n == m_done) begin
                    e_done = 1'b1;
                    m_active = 0;
                end
            end
            if (m_ack >= 0 && n == m_ack + 1) begin
                if (m_ack_err) e_err = 1'b1;
                else           e_done = 1'b1;
                m_ack = -1;
            end
            if (was_idle && !was_ready && (va || vb)) begin
                win_b = (va && vb) ? !m_grant : vb;
                r = win_b ? int'(rb) : int'(ra);
                m_grant = win_b;
                e_ready_a = !win_b;
                e_ready_b = win_b;
                if (CHK && r < 2) begin
                    m_ack = n; m_ack_err = 1'b1;
                end else if (r == m_ratio) begin
                    m_ack = n; m_ack_err = 1'b0;
                end else begin
                    m_active = 1; m_a = n; m_R = r; m_done = -1;
                end
            end
            e_busy  = (m_active != 0);
            e_grant = m_grant;
            e_ratio = m_ratio;
        end
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        if (act != exp) begin
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
            n_miss++;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        cmp(name, act, exp);
    endtask

    // One clock: update the model at the edge, compare on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        n_vec++;
        if (rst) begin
            cmp("rst_ready_a", int'(ready_a), 0);
            cmp("rst_ready_b", int'(ready_b), 0);
            cmp("rst_ratio",   int'(div_ratio), int'(RST_R));
            cmp("rst_clk_en",  int'(clk_en), 0);
            cmp("rst_busy",    int'(busy), 0);
            cmp("rst_done",    int'(cfg_done), 0);
            cmp("rst_grant",   int'(grant_id), 1);
`ifdef CLKDIV_SEQ_RATIO_CHECK_EN
            cmp("rst_err",     int'(cfg_err), 0);
`endif
        end else begin
            cmp("ready_a",  int'(ready_a),   int'(e_ready_a));
            cmp("ready_b",  int'(ready_b),   int'(e_ready_b));
            cmp("ratio",    int'(div_ratio), e_ratio);
            cmp("clk_en",   int'(clk_en),    int'(e_en));
            cmp("busy",     int'(busy),      int'(e_busy));
            cmp("cfg_done", int'(cfg_done),  int'(e_done));
            cmp("grant",    int'(grant_id),  int'(e_grant));
`ifdef CLKDIV_SEQ_RATIO_CHECK_EN
            cmp("cfg_err",  int'(cfg_err),   int'(e_err));
`endif
        end
    endtask

    function automatic bit sig(input int w);
        case (w)
            0:       return ready_a;
            1:       return ready_b;
            default: return cfg_done;
        endcase
    endfunction

    task automatic wait_for(input int which, input int bound, output int took);
        took = -1;
        for (int i = 1; i <= bound; i++) begin
            cycle();
            if (sig(which)) begin
                took = i;
                break;
            end
        end
        if (took < 0) begin
            $display("FAIL wait_event_%0d got=timeout want=event within %0d cycles", which, bound);
            n_miss++;
        end
    endtask

    initial begin
        int  t, k, low;
        bit  a_got, b_got;

        rst = 1'b1; en = 1'b1; va = 1'b0; vb = 1'b0; ra = '0; rb = '0;

        // Reset values, then o_clk_en follows i_enable one cycle after release.
        cycle(); cycle();
        chk("reset_ratio", int'(div_ratio), 2);
        chk("reset_clk_en", int'(clk_en), 0);
        chk("reset_grant", int'(grant_id), 1);
        rst = 1'b0;
        cycle();
        chk("release_clk_en", int'(clk_en), 1);
        chk("release_busy", int'(busy), 0);

        // B asks for the ratio already in force: ack, done next cycle, no gating.
        vb = 1'b1; rb = 8'd2;
        wait_for(1, 10, t);
        chk("same_grant", int'(grant_id), 1);
        cycle();
        chk("same_done", int'(cfg_done), 1);
        chk("same_busy", int'(busy), 0);
        chk("same_clk_en", int'(clk_en), 1);
        vb = 1'b0;

        // Both valid with grant=1: A (4) first, then B (9) right after A's done.
        va = 1'b1; ra = 8'd4; vb = 1'b1; rb = 8'd9;
        wait_for(0, 10, t);
        chk("rr_first_grant", int'(grant_id), 0);
        chk("rr_first_b_ready", int'(ready_b), 0);
        cycle();
        va = 1'b0;
        wait_for(2, 40, t);
        chk("rr_a_ratio", int'(div_ratio), 4);
        cycle();
        chk("rr_b_ready", int'(ready_b), 1);
        chk("rr_second_grant", int'(grant_id), 1);
        cycle();
        vb = 1'b0;
        wait_for(2, 40, t);
        chk("rr_b_ratio", int'(div_ratio), 9);

        // A asks for 6: done 12 cycles after accept, gate low 4 cycles first.
        va = 1'b1; ra = 8'd6;
        wait_for(0, 10, t);
        k = 0; low = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            k++;
            if (k == 1) va = 1'b0;
            if (!clk_en && div_ratio != 8'd6) low++;
            if (cfg_done) break;
        end
        chk("r6_latency", k, 12);
        chk("r6_gate_low", low, 4);
        chk("r6_ratio", int'(div_ratio), 6);

        // A asks for 8; i_enable drops during SETTLE.
        va = 1'b1; ra = 8'd8;
        wait_for(0, 10, t);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            k++;
            if (k == 1) va = 1'b0;
            if (k == 9) chk("r8_en_drop", int'(clk_en), 0);
            if (k == 8) en = 1'b0;
            if (cfg_done) break;
        end
        chk("r8_latency", k, 14);
        cycle();
        chk("r8_en_after", int'(clk_en), 0);
        en = 1'b1;
        cycle();

        // Reset in the middle of a sequence discards the captured ratio.
        va = 1'b1; ra = 8'd20;
        wait_for(0, 10, t);
        cycle(); cycle();
        rst = 1'b1; va = 1'b0;
        cycle();
        chk("midrst_ratio", int'(div_ratio), 2);
        chk("midrst_busy", int'(busy), 0);
        rst = 1'b0;
        cycle();
        chk("midrst_after_ratio", int'(div_ratio), 2);
        chk("midrst_after_en", int'(clk_en), 1);

        // Ratio 1: rejected with the check enabled, otherwise applied.
        va = 1'b1; ra = 8'd1;
        wait_for(0, 10, t);
`ifdef CLKDIV_SEQ_RATIO_CHECK_EN
        cycle();
        va = 1'b0;
        chk("r1_err", int'(cfg_err), 1);
        chk("r1_no_done", int'(cfg_done), 0);
        chk("r1_ratio", int'(div_ratio), 2);
        for (int i = 0; i < 10; i++) cycle();
`else
        k = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            k++;
            if (k == 1) va = 1'b0;
            if (cfg_done) break;
        end
        chk("r1_latency", k, 7);
        chk("r1_ratio", int'(div_ratio), 1);
`endif

        // Randomized traffic, enable toggling and occasional resets.
        a_got = 1'b0; b_got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 599) == 0) rst = 1'b1;
            if (a_got) begin
                va = 1'b0; a_got = 1'b0;
            end else if (va && ready_a) begin
                a_got = 1'b1;
            end else if (!va && $urandom_range(0, 5) == 0) begin
                va = 1'b1; ra = 8'($urandom_range(0, 12));
            end
            if (b_got) begin
                vb = 1'b0; b_got = 1'b0;
            end else if (vb && ready_b) begin
                b_got = 1'b1;
            end else if (!vb && $urandom_range(0, 5) == 0) begin
                vb = 1'b1; rb = 8'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 29) == 0) en = ~en;
        end
        rst = 1'b0; va = 1'b0; vb = 1'b0;
        for (int i = 0; i < 60; i++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
